// File: rtl/smi_frame_arbiter_x4_pkg.sv
// Shared SMI constants and types for the four-way frame arbiter.
package smi_frame_arbiter_x4_pkg;

  localparam int EofcWidth = 8;
  localparam int NumPorts  = 4;

  typedef logic [1:0] portIdx_t;

  localparam portIdx_t PORT_A = 2'd0;
  localparam portIdx_t PORT_B = 2'd1;
  localparam portIdx_t PORT_C = 2'd2;
  localparam portIdx_t PORT_D = 2'd3;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arbState_t;

  function automatic portIdx_t nextPort(input portIdx_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/smi_rr_arbiter4.sv
// Round-robin pick over four requesters, searching upward from rrPtr; rrPtr advances past the winner on request.
module smi_rr_arbiter4
  import smi_frame_arbiter_x4_pkg::*;
(
  input  logic                clk,
  input  logic                srst,
  input  logic [NumPorts-1:0] req,
  input  logic                advance,
  input  portIdx_t            advanceFrom,
  output portIdx_t            pick,
  output logic                anyReq
);

  portIdx_t rrPtr;
  portIdx_t cand;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick   = rrPtr;
    anyReq = 1'b0;
    cand   = rrPtr;
    // Walk from the farthest offset down so the nearest requester to rrPtr wins.
    for (int i = NumPorts - 1; i >= 0; i--) begin
      cand = rrPtr + portIdx_t'(i);
      if (req[cand]) begin
        pick   = cand;
        anyReq = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (srst) begin
      rrPtr <= PORT_A;
    end else if (advance) begin
      rrPtr <= nextPort(advanceFrom);
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x4.sv
// Frame-atomic round-robin merge of four SMI inputs onto one SMI output.
// Optional output FIFO in place of the output register: define SMI_FRAME_ARBITER_OUT_FIFO_EN.
module smi_frame_arbiter_x4
  import smi_frame_arbiter_x4_pkg::*;
#(
  parameter int FlitWidth     = 16,
  parameter int EofcMask      = 2 * FlitWidth - 1,
  parameter int FifoSize      = 16,
  parameter int FifoIndexSize = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   smiInAReady,
  input  logic [7:0]             smiInAEofc,
  input  logic [FlitWidth*8-1:0] smiInAData,
  output logic                   smiInAStop,
  input  logic                   smiInBReady,
  input  logic [7:0]             smiInBEofc,
  input  logic [FlitWidth*8-1:0] smiInBData,
  output logic                   smiInBStop,
  input  logic                   smiInCReady,
  input  logic [7:0]             smiInCEofc,
  input  logic [FlitWidth*8-1:0] smiInCData,
  output logic                   smiInCStop,
  input  logic                   smiInDReady,
  input  logic [7:0]             smiInDEofc,
  input  logic [FlitWidth*8-1:0] smiInDData,
  output logic                   smiInDStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);

  localparam int DataWidth = FlitWidth * 8;
  localparam logic [EofcWidth-1:0] EofcMaskBits = EofcWidth'(EofcMask);

  if (FlitWidth < 4 || FifoSize <= 3 || (1 << FifoIndexSize) < FifoSize) begin : gBadParams
    $error("smi_frame_arbiter_x4: invalid parameter set");
  end

  logic [NumPorts-1:0]  inValid;
  logic [EofcWidth-1:0] inEofc [NumPorts];
  logic [DataWidth-1:0] inData [NumPorts];

  always_comb begin
    inValid         = '0;
    inValid[PORT_A] = smiInAReady;
    inValid[PORT_B] = smiInBReady;
    inValid[PORT_C] = smiInCReady;
    inValid[PORT_D] = smiInDReady;
    inEofc[PORT_A]  = smiInAEofc;
    inEofc[PORT_B]  = smiInBEofc;
    inEofc[PORT_C]  = smiInCEofc;
    inEofc[PORT_D]  = smiInDEofc;
    inData[PORT_A]  = smiInAData;
    inData[PORT_B]  = smiInBData;
    inData[PORT_C]  = smiInCData;
    inData[PORT_D]  = smiInDData;
  end

  logic [NumPorts-1:0]  inReady_q;
  logic [EofcWidth-1:0] inEofc_q [NumPorts];
  logic [DataWidth-1:0] inData_q [NumPorts];
  logic [NumPorts-1:0]  take;
  logic [NumPorts-1:0]  inStop;

  arbState_t state;
  portIdx_t  lockPort;
  portIdx_t  pick;
  portIdx_t  grant;
  logic      anyReq;
  logic      active;
  logic      outLoad;
  logic      anyTake;
  logic      takeLast;

  smi_rr_arbiter4 uRrArbiter (
    .clk         (clk),
    .srst        (srst),
    .req         (inReady_q),
    .advance     (takeLast),
    .advanceFrom (grant),
    .pick        (pick),
    .anyReq      (anyReq)
  );

  // While locked only the owning port may move, even if it is idle mid-frame.
  assign grant    = (state == ARB_LOCKED) ? lockPort : pick;
  assign active   = (state == ARB_LOCKED) ? inReady_q[lockPort] : anyReq;
  assign anyTake  = active & outLoad;
  assign takeLast = anyTake & (inEofc_q[grant] != '0);

  always_comb begin
    take = '0;
    if (anyTake) take[grant] = 1'b1;
  end

  assign inStop     = inReady_q & ~take;
  assign smiInAStop = inStop[PORT_A];
  assign smiInBStop = inStop[PORT_B];
  assign smiInCStop = inStop[PORT_C];
  assign smiInDStop = inStop[PORT_D];

  always_ff @(posedge clk) begin
    if (srst) begin
      inReady_q <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (!inStop[i]) inReady_q[i] <= inValid[i];
      end
    end
  end

  // NOTE: payload registers carry no reset; the valid flags alone qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (!inStop[i]) begin
        inEofc_q[i] <= inEofc[i];
        inData_q[i] <= inData[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= ARB_IDLE;
      lockPort <= PORT_A;
    end else if (anyTake) begin
      if (takeLast) begin
        state <= ARB_IDLE;
      end else begin
        state    <= ARB_LOCKED;
        lockPort <= grant;
      end
    end
  end

`ifdef SMI_FRAME_ARBITER_OUT_FIFO_EN
  logic fifoStop;

  assign outLoad = ~fifoStop;

  selfLinkBufferFifoS #(
    .Width     ((FlitWidth + 1) * 8),
    .Depth     (FifoSize),
    .IndexSize (FifoIndexSize)
  ) uOutFifo (
    .clk         (clk),
    .srst        (srst),
    .smiInReady  (anyTake),
    .smiInData   ({inEofc_q[grant] & EofcMaskBits, inData_q[grant]}),
    .smiInStop   (fifoStop),
    .smiOutReady (smiOutReady),
    .smiOutData  ({smiOutEofc, smiOutData}),
    .smiOutStop  (smiOutStop)
  );
`else
  logic                 outReady_q;
  logic [EofcWidth-1:0] outEofc_q;
  logic [DataWidth-1:0] outData_q;

  assign outLoad = ~(outReady_q & smiOutStop);

  always_ff @(posedge clk) begin
    if (srst) begin
      outReady_q <= 1'b0;
    end else if (outLoad) begin
      outReady_q <= anyTake;
    end
  end

  always_ff @(posedge clk) begin
    if (outLoad) begin
      outEofc_q <= inEofc_q[grant] & EofcMaskBits;
      outData_q <= inData_q[grant];
    end
  end

  assign smiOutReady = outReady_q;
  assign smiOutEofc  = outEofc_q;
  assign smiOutData  = outData_q;
`endif

endmodule

// File: tb/tb_smi_frame_arbiter_x4.sv
// Self-checking bench for smi_frame_arbiter_x4: directed scenarios then randomized traffic against a per-port scoreboard.
module tb_smi_frame_arbiter_x4;

  localparam int FW = 16;
  localparam int DW = FW * 8;
  localparam logic [7:0] MASK = 8'(2 * FW - 1);

  typedef struct packed {
    logic [31:0]   tin;
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  logic          clk = 1'b0;
  logic          srst;
  logic [3:0]    inReady;
  logic [7:0]    inEofc [4];
  logic [DW-1:0] inData [4];
  wire  [3:0]    inStop;
  logic          smiOutStop;
  wire           smiOutReady;
  wire  [7:0]    smiOutEofc;
  wire  [DW-1:0] smiOutData;

  always #5 clk = ~clk;

  smi_frame_arbiter_x4 #(.FlitWidth(FW)) dut (
    .clk         (clk),
    .srst        (srst),
    .smiInAReady (inReady[0]),
    .smiInAEofc  (inEofc[0]),
    .smiInAData  (inData[0]),
    .smiInAStop  (inStop[0]),
    .smiInBReady (inReady[1]),
    .smiInBEofc  (inEofc[1]),
    .smiInBData  (inData[1]),
    .smiInBStop  (inStop[1]),
    .smiInCReady (inReady[2]),
    .smiInCEofc  (inEofc[2]),
    .smiInCData  (inData[2]),
    .smiInCStop  (inStop[2]),
    .smiInDReady (inReady[3]),
    .smiInDEofc  (inEofc[3]),
    .smiInDData  (inData[3]),
    .smiInDStop  (inStop[3]),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (smiOutStop)
  );

  // Reference model: flits waiting to be offered, and flits accepted but not yet seen on the output, per port.
  flit_t         srcQ [4][$];
  flit_t         expQ [4][$];
  flit_t         drvFlit [4];
  logic [3:0]    drvValid;
  int            outPortLog[$];
  int            outCycleLog[$];
  int            checks, failures, cycleCnt, validPct, stopPct, seq, totalAdded;
  logic          stopForce, latencyEn, holdEn, midFrame;
  logic [1:0]    curPort;
  logic [DW-1:0] holdData;
  logic [7:0]    lastOutEofc;
  logic [3:0]    sawStop;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addFrame(input int p, input int len, input logic [7:0] lastEofc);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.data       = {$urandom(), $urandom(), $urandom(), $urandom()};
      f.data[17:2] = 16'(seq);
      f.data[1:0]  = 2'(p);
      f.eofc       = (i == len - 1) ? lastEofc : 8'h00;
      f.tin        = '0;
      seq++;
      totalAdded++;
      srcQ[p].push_back(f);
    end
  endtask

  task automatic observeOut();
    flit_t      e;
    logic [1:0] p;
    p = smiOutData[1:0];
    if (midFrame) check("frameAtomic", p, curPort);
    check("flitExpected", expQ[p].size() > 0, 1);
    if (expQ[p].size() > 0) begin
      e = expQ[p].pop_front();
      check("outData", smiOutData, e.data);
      check("outEofc", smiOutEofc, e.eofc & MASK);
      if (latencyEn) check("latency", cycleCnt - int'(e.tin), 2);
      midFrame = (e.eofc == 8'h00);
    end else begin
      midFrame = 1'b0;
    end
    curPort     = p;
    lastOutEofc = smiOutEofc;
    outPortLog.push_back(int'(p));
    outCycleLog.push_back(cycleCnt);
  endtask

  // One clock: drive at the falling edge, resolve transfers just after, then cross the rising edge.
  task automatic step();
    flit_t f;
    for (int p = 0; p < 4; p++) begin
      if (!drvValid[p] && srcQ[p].size() > 0 && $urandom_range(99) < validPct) begin
        drvFlit[p]  = srcQ[p].pop_front();
        drvValid[p] = 1'b1;
      end
      inReady[p] = drvValid[p];
      inEofc[p]  = drvValid[p] ? drvFlit[p].eofc : 8'h00;
      inData[p]  = drvValid[p] ? drvFlit[p].data : '0;
    end
    smiOutStop = stopForce || ($urandom_range(99) < stopPct);
    #1;
    sawStop |= inStop;
    if (holdEn) begin
      check("holdReady", smiOutReady, 1);
      check("holdData", smiOutData, holdData);
      check("holdStopB", inStop[1], 1);
    end
    for (int p = 0; p < 4; p++) begin
      if (drvValid[p] && !inStop[p]) begin
        f     = drvFlit[p];
        f.tin = 32'(cycleCnt);
        expQ[p].push_back(f);
        drvValid[p] = 1'b0;
      end
    end
    if (smiOutReady && !smiOutStop) observeOut();
    @(posedge clk);
    @(negedge clk);
    cycleCnt++;
  endtask

  function automatic bit busy();
    bit b;
    b = (drvValid != 4'b0000);
    for (int p = 0; p < 4; p++) begin
      if (srcQ[p].size() > 0 || expQ[p].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic drain(input string tag, input int maxSteps);
    int n;
    n = 0;
    while (busy() && n < maxSteps) begin
      step();
      n++;
    end
    check(tag, busy(), 0);
  endtask

  task automatic doReset();
    srst       = 1'b1;
    drvValid   = '0;
    inReady    = '0;
    smiOutStop = 1'b0;
    stopForce  = 1'b0;
    for (int p = 0; p < 4; p++) begin
      srcQ[p].delete();
      expQ[p].delete();
      inEofc[p] = 8'h00;
      inData[p] = '0;
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    srst     = 1'b0;
    midFrame = 1'b0;
    sawStop  = '0;
    outPortLog.delete();
    outCycleLog.delete();
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cycleCnt = 0; seq = 0; totalAdded = 0;
    validPct = 100; stopPct = 0;
    stopForce = 1'b0; latencyEn = 1'b0; holdEn = 1'b0; midFrame = 1'b0;
    curPort = '0; sawStop = '0; drvValid = '0; holdData = '0; lastOutEofc = '0;
    srst = 1'b1; inReady = '0; smiOutStop = 1'b0;
    for (int p = 0; p < 4; p++) begin
      inEofc[p] = 8'h00;
      inData[p] = '0;
    end
    @(negedge clk);

    // Reset state
    doReset();
    check("rstOutReady", smiOutReady, 0);
    check("rstStops", inStop, 4'b0000);

    // Single 3-flit frame on A: 2-cycle latency, back-to-back, no stops elsewhere
    latencyEn = 1'b1;
    addFrame(0, 3, 8'd16);
    drain("t1Drain", 20);
    latencyEn = 1'b0;
    check("t1Count", outPortLog.size(), 3);
    check("t1BackToBack", outCycleLog[2] - outCycleLog[0], 2);
    check("t1OtherStops", sawStop[3:1], 3'b000);

    // A and C request together: all of A then all of C, no bubble
    doReset();
    addFrame(0, 4, 8'd16);
    addFrame(2, 4, 8'd16);
    drain("t2Drain", 40);
    check("t2Count", outPortLog.size(), 8);
    for (int i = 0; i < 8; i++) check("t2Order", outPortLog[i], (i < 4) ? 0 : 2);
    check("t2NoBubble", outCycleLog[7] - outCycleLog[0], 7);
    check("t2StopC", sawStop[2], 1);

    // Four ports streaming single-flit frames: A,B,C,D rotation at one flit per cycle
    doReset();
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) addFrame(p, 1, 8'($urandom_range(16, 1)));
    end
    drain("t3Drain", 60);
    check("t3Count", outPortLog.size(), 24);
    for (int i = 0; i < 24; i++) check("t3Order", outPortLog[i], i % 4);
    check("t3Rate", outCycleLog[23] - outCycleLog[0], 23);

    // Downstream stall of 5 cycles mid-frame from B
    outPortLog.delete();
    outCycleLog.delete();
    addFrame(1, 6, 8'd16);
    n = 0;
    while (outPortLog.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("t4Reached", outPortLog.size() >= 2, 1);
    check("t4ReadyBeforeStall", smiOutReady, 1);
    holdData  = smiOutData;
    stopForce = 1'b1;
    holdEn    = 1'b1;
    repeat (5) step();
    holdEn    = 1'b0;
    stopForce = 1'b0;
    drain("t4Drain", 30);
    check("t4Count", outPortLog.size(), 6);

    // Oversized eofc is masked on the output
    addFrame(3, 1, 8'hFF);
    drain("t5Drain", 20);
    check("t5Eofc", lastOutEofc, 8'h1F);

    // Reset while locked on D: output cleared, rotation restarts at A
    outPortLog.delete();
    outCycleLog.delete();
    addFrame(1, 1, 8'd5);
    drain("t6PreDrain", 20);
    addFrame(3, 6, 8'd16);
    n = 0;
    while (outPortLog.size() < 3 && n < 20) begin
      step();
      n++;
    end
    check("t6MidFrame", outPortLog.size() >= 3, 1);
    doReset();
    check("t6RstReady", smiOutReady, 0);
    check("t6RstStops", inStop, 4'b0000);
    addFrame(1, 1, 8'd4);
    addFrame(2, 1, 8'd4);
    addFrame(3, 1, 8'd4);
    addFrame(0, 1, 8'd4);
    drain("t6Drain", 20);
    check("t6Count", outPortLog.size(), 4);
    for (int i = 0; i < 4; i++) check("t6Order", outPortLog[i], i);

    // Randomized traffic with random gaps and downstream backpressure
    outPortLog.delete();
    outCycleLog.delete();
    totalAdded = 0;
    validPct   = 70;
    stopPct    = 30;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) addFrame(p, $urandom_range(5, 1), 8'($urandom_range(16, 1)));
    end
    drain("randDrain", 3000);
    check("randCount", outPortLog.size(), totalAdded);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
